// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU datapath: sequencer FSM states,
// PC increment and default field widths.
package cpu_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } pc_state_t;

   localparam int PC_INC        = 4;
   localparam int PC_W_DEFAULT  = 32;
   localparam int OFF_W_DEFAULT = 8;
   localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/pc_target_adder.sv
// Computes the sequential PC and the offset branch/jump target.
// Offsets are signed word counts; all sums wrap modulo 2^PC_W.
module pc_target_adder
   import cpu_pkg::*;
#(
   parameter int PC_W  = PC_W_DEFAULT,
   parameter int OFF_W = OFF_W_DEFAULT
) (
   input  logic [PC_W-1:0]  pc,
   input  logic [OFF_W-1:0] offset,
   output logic [PC_W-1:0]  seq,
   output logic [PC_W-1:0]  tgt
);

   logic [PC_W-1:0] off_ext_s;
   logic [PC_W-1:0] off_bytes_s;

   // sign-extend the word offset, scale to bytes, form both candidate PCs
   always_comb begin
      off_ext_s   = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
      off_bytes_s = off_ext_s << 2;
      seq         = pc + PC_W'(PC_INC);
      tgt         = seq + off_bytes_s;
   end

endmodule

// File: rtl/pc_branch_ctrl.sv
// Program-counter sequencer with branch resolution, stall capture/replay
// and a saturating taken-redirect counter.
module pc_branch_ctrl
   import cpu_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEFAULT,
   parameter int              OFF_W    = OFF_W_DEFAULT,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = CNT_W_DEFAULT
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              BUSYWAIT,
   input  logic              ZERO,
   input  logic              BRANCH,
   input  logic              BNE,
   input  logic              JUMP,
   input  logic [OFF_W-1:0]  OFFSET,
   output logic [PC_W-1:0]   PC,
   output logic              BR_TAKEN,
   output logic [CNT_W-1:0]  TAKEN_CNT
);

   pc_state_t        state_r;
   logic [PC_W-1:0]  pc_r;
   logic [PC_W-1:0]  pend_pc_r;
   logic             pend_valid_r;
   logic             br_taken_r;
   logic [CNT_W-1:0] cnt_r;

   logic             take_s;
   logic [PC_W-1:0]  seq_s;
   logic [PC_W-1:0]  tgt_s;
   logic [PC_W-1:0]  next_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   pc_target_adder #(
      .PC_W  (PC_W),
      .OFF_W (OFF_W)
   ) u_target (
      .pc     (pc_r),
      .offset (OFFSET),
      .seq    (seq_s),
      .tgt    (tgt_s)
   );

   // branch decision: the highest-priority asserted decode alone decides
   always_comb begin
      take_s = 1'b0;
      if (JUMP) begin
         take_s = 1'b1;
      end else if (BRANCH) begin
         take_s = ZERO;
      end else if (BNE) begin
         take_s = ~ZERO;
      end else begin
         take_s = 1'b0;
      end
      next_s = take_s ? tgt_s : seq_s;
   end

   // sequencer FSM: advance, capture decision on stall entry, replay on release
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r      <= ST_RUN;
         pc_r         <= RESET_PC;
         pend_pc_r    <= {PC_W{1'b0}};
         pend_valid_r <= 1'b0;
         br_taken_r   <= 1'b0;
         cnt_r        <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_RUN: begin
               if (BUSYWAIT) begin
                  pend_pc_r    <= next_s;
                  pend_valid_r <= take_s;
                  br_taken_r   <= 1'b0;
                  state_r      <= ST_STALL;
               end else begin
                  pc_r       <= next_s;
                  br_taken_r <= take_s;
                  if (take_s) begin
                     cnt_r <= sat_inc(cnt_r);
                  end
               end
            end
            ST_STALL: begin
               if (BUSYWAIT) begin
                  br_taken_r <= 1'b0;
               end else begin
                  pc_r         <= pend_pc_r;
                  br_taken_r   <= pend_valid_r;
                  pend_valid_r <= 1'b0;
                  state_r      <= ST_RUN;
                  if (pend_valid_r) begin
                     cnt_r <= sat_inc(cnt_r);
                  end
               end
            end
            default: begin
               state_r      <= ST_RUN;
               pend_valid_r <= 1'b0;
               br_taken_r   <= 1'b0;
            end
         endcase
      end
   end

   assign PC        = pc_r;
   assign BR_TAKEN  = br_taken_r;
   assign TAKEN_CNT = cnt_r;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed self-checking bench for pc_branch_ctrl: a vector table for the
// straight-line cases plus hand-written stall, reset and wrap sequences.
module tb_pc_branch_ctrl;

   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   logic        busy, zero, br, bne, jmp;
   logic [7:0]  off;

   logic [31:0] pc_a, pc_b;
   logic        brt_a, brt_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pc_branch_ctrl dut_a (
      .CLK(clk), .RESET(rst_a), .BUSYWAIT(busy), .ZERO(zero), .BRANCH(br),
      .BNE(bne), .JUMP(jmp), .OFFSET(off), .PC(pc_a), .BR_TAKEN(brt_a),
      .TAKEN_CNT(cnt_a)
   );

   pc_branch_ctrl #(.CNT_W(2), .RESET_PC(32'hFFFF_FFFC)) dut_b (
      .CLK(clk), .RESET(rst_b), .BUSYWAIT(busy), .ZERO(zero), .BRANCH(br),
      .BNE(bne), .JUMP(jmp), .OFFSET(off), .PC(pc_b), .BR_TAKEN(brt_b),
      .TAKEN_CNT(cnt_b)
   );

   typedef struct {
      string       name;
      logic        busy, zero, br, bne, jmp;
      logic [7:0]  off;
      logic [31:0] exp_pc;
      logic        exp_br;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string n, input logic b, input logic z, input logic be,
                      input logic bn, input logic j, input logic [7:0] o,
                      input logic [31:0] epc, input logic ebr, input logic [15:0] ecnt);
      vec_t v;
      v.name = n; v.busy = b; v.zero = z; v.br = be; v.bne = bn; v.jmp = j;
      v.off = o; v.exp_pc = epc; v.exp_br = ebr; v.exp_cnt = ecnt;
      vecs.push_back(v);
   endtask

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
      end
   endtask

   task automatic drive(input logic b, input logic z, input logic be, input logic bn,
                        input logic j, input logic [7:0] o);
      busy = b; zero = z; br = be; bne = bn; jmp = j; off = o;
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string n, input logic [31:0] epc, input logic ebr,
                          input logic [15:0] ecnt);
      check({n, "_pc"},  pc_a, epc);
      check({n, "_br"},  {31'd0, brt_a}, {31'd0, ebr});
      check({n, "_cnt"}, {16'd0, cnt_a}, {16'd0, ecnt});
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      busy = 1'b0; zero = 1'b0; br = 1'b0; bne = 1'b0; jmp = 1'b0; off = 8'h00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_a("reset", 32'h0, 1'b0, 16'd0);
      check("reset_b_pc", pc_b, 32'hFFFF_FFFC);
      rst_a = 1'b0; rst_b = 1'b0;

      // name        busy zero br  bne jmp off     pc            br  cnt
      add("run4",    0,   0,   0,  0,  0,  8'h00, 32'h0000_0004, 0,  16'd0);
      add("run8",    0,   0,   0,  0,  0,  8'h00, 32'h0000_0008, 0,  16'd0);
      add("run12",   0,   0,   0,  0,  0,  8'h00, 32'h0000_000C, 0,  16'd0);
      add("jmp0",    0,   0,   0,  0,  1,  8'h00, 32'h0000_0010, 1,  16'd1);
      add("beq_t",   0,   1,   1,  0,  0,  8'hFE, 32'h0000_000C, 1,  16'd2);
      add("seq_10",  0,   0,   0,  0,  0,  8'h00, 32'h0000_0010, 0,  16'd2);
      add("beq_nt",  0,   0,   1,  0,  0,  8'hFE, 32'h0000_0014, 0,  16'd2);
      add("jmp2",    0,   0,   0,  0,  1,  8'h02, 32'h0000_0020, 1,  16'd3);
      add("bne_t",   0,   0,   0,  1,  0,  8'h03, 32'h0000_0030, 1,  16'd4);
      add("jmp_pri", 0,   0,   1,  0,  1,  8'h01, 32'h0000_0038, 1,  16'd5);
      add("bne_nt",  0,   1,   0,  1,  0,  8'h05, 32'h0000_003C, 0,  16'd5);
      add("seq_40",  0,   0,   0,  0,  0,  8'h00, 32'h0000_0040, 0,  16'd5);

      foreach (vecs[i]) begin
         drive(vecs[i].busy, vecs[i].zero, vecs[i].br, vecs[i].bne, vecs[i].jmp, vecs[i].off);
         check_a(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_br, vecs[i].exp_cnt);
      end

      // stall replay: beq taken captured at 0x40, inputs scrambled during the stall
      drive(1, 1, 1, 0, 0, 8'h02);  check_a("stall_in", 32'h40, 1'b0, 16'd5);
      drive(1, 0, 0, 0, 1, 8'h07);  check_a("stall_h1", 32'h40, 1'b0, 16'd5);
      drive(1, 0, 0, 1, 0, 8'h09);  check_a("stall_h2", 32'h40, 1'b0, 16'd5);
      drive(0, 0, 0, 0, 1, 8'h10);  check_a("replay",   32'h4C, 1'b1, 16'd6);
      drive(0, 0, 0, 0, 0, 8'h00);  check_a("post_rep", 32'h50, 1'b0, 16'd6);

      // stall with a not-taken decision releases to the sequential PC
      drive(1, 0, 0, 0, 0, 8'h00);  check_a("nt_stall", 32'h50, 1'b0, 16'd6);
      drive(0, 0, 0, 0, 1, 8'h20);  check_a("nt_rel",   32'h54, 1'b0, 16'd6);

      // reset during a stall with a pending taken jump discards it
      drive(1, 0, 0, 0, 1, 8'h01);  check_a("rst_stall", 32'h54, 1'b0, 16'd6);
      rst_a = 1'b1;
      drive(1, 0, 0, 0, 0, 8'h00);  check_a("rst_mid",   32'h0, 1'b0, 16'd0);
      rst_a = 1'b0;
      drive(0, 0, 0, 0, 0, 8'h00);  check_a("no_replay", 32'h4, 1'b0, 16'd0);

      // wrap and saturation on the narrow-counter instance
      rst_b = 1'b1;
      drive(0, 0, 0, 0, 0, 8'h00);
      check("b_rst_pc", pc_b, 32'hFFFF_FFFC);
      check("b_rst_cnt", {30'd0, cnt_b}, 32'd0);
      rst_b = 1'b0;
      drive(0, 0, 0, 0, 0, 8'h00);  check("b_wrap_pc", pc_b, 32'h0);
      drive(0, 0, 0, 0, 1, 8'h00);  check("b_j1_cnt", {30'd0, cnt_b}, 32'd1);
      drive(0, 0, 0, 0, 1, 8'h00);  check("b_j2_cnt", {30'd0, cnt_b}, 32'd2);
      drive(0, 0, 0, 0, 1, 8'h00);  check("b_j3_cnt", {30'd0, cnt_b}, 32'd3);
      drive(0, 0, 0, 0, 1, 8'h00);
      check("b_j4_cnt", {30'd0, cnt_b}, 32'd3);
      check("b_j4_pc", pc_b, 32'h10);
      check("b_j4_br", {31'd0, brt_b}, 32'd1);
      drive(0, 0, 0, 0, 1, 8'hF8);
      check("b_neg_pc", pc_b, 32'hFFFF_FFF4);
      check("b_neg_cnt", {30'd0, cnt_b}, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
